// File: rtl/camera_angle_scheduler.sv
// camera_angle_scheduler
//   Arbitrates four motion zones and a remote operator for the single pan
//   drive of smart_camera. One angle command is in flight at a time. After
//   the drive accepts it, the scheduler holds position for a dwell window
//   (motion command) or a hold window (manual command).
//
// Optional feature macro: CAM_PATROL_EN
//   When defined, PATROL_CYCLES consecutive request-free IDLE cycles issue a
//   patrol step to cur_angle+1 (mode 11). When undefined, IDLE waits
//   indefinitely and mode never reads 11.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   motion_zone  in   [3:0] per-zone motion level, zone i -> angle i
//   remote_req   in   single-cycle remote command strobe
//   remote_angle in   [1:0] remote target angle, sampled with remote_req
//   cmd_valid    out  angle command valid to the camera drive
//   cmd_angle    out  [1:0] commanded angle
//   cmd_ready    in   camera drive accepts the command
//   cur_angle    out  [1:0] last accepted angle
//   mode         out  [1:0] 00 idle, 01 motion, 10 manual, 11 patrol
//   busy         out  high in any state other than IDLE
//   state_dbg    out  [1:0] raw FSM state for observation
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid rises, cmd_angle and mode hold
// steady until that transfer; cmd_valid never drops without a transfer
// except on reset.

module camera_angle_scheduler #(
    parameter int DWELL_CYCLES  = 16,
    parameter int MANUAL_HOLD   = 64,
    parameter int PATROL_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] motion_zone,
    input  logic       remote_req,
    input  logic [1:0] remote_angle,
    output logic       cmd_valid,
    output logic [1:0] cmd_angle,
    input  logic       cmd_ready,
    output logic [1:0] cur_angle,
    output logic [1:0] mode,
    output logic       busy,
    output logic [1:0] state_dbg
);

`ifdef CAM_PATROL_EN
    localparam bit PATROL_EN = 1'b1;
`else
    localparam bit PATROL_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(MANUAL_HOLD - 1);
    localparam logic [CNT_W-1:0] PATROL_LAST = CNT_W'(PATROL_CYCLES - 1);

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_MOTION = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;
    localparam logic [1:0] MODE_PATROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DWELL  = 2'd2,
        S_MANUAL = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [3:0]       pend;
    logic             rem_pend;
    logic [1:0]       rem_angle;
    logic [1:0]       rr_ptr;
    logic [1:0]       issue_mode;
    logic [CNT_W-1:0] counter;

    logic [3:0]       eff_zone;
    logic             eff_rem;
    logic [1:0]       eff_rem_angle;
    logic             rr_found;
    logic [1:0]       rr_winner;
    logic             transfer;
    logic             issue_load;
    logic [1:0]       issue_mode_n;
    logic [1:0]       issue_angle_n;
    logic [3:0]       zone_clr;

    // Decisions see latched requests plus whatever arrives this cycle, so a
    // single-cycle strobe is acted on at the very edge that samples it.
    assign eff_zone      = pend | motion_zone;
    assign eff_rem       = rem_pend | remote_req;
    assign eff_rem_angle = remote_req ? remote_angle : rem_angle;

    assign cmd_valid = (state == S_ISSUE);
    assign transfer  = cmd_valid & cmd_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Only a motion transfer retires a zone bit; the zone is the angle.
    assign zone_clr = (transfer && issue_mode == MODE_MOTION) ? (4'b0001 << cmd_angle) : 4'b0000;

    // Round-robin search starting at rr_ptr; 2-bit index arithmetic wraps.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!rr_found && eff_zone[rr_ptr + 2'(k)]) begin
                rr_found  = 1'b1;
                rr_winner = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        case (state)
            S_ISSUE:  mode = issue_mode;
            S_DWELL:  mode = MODE_MOTION;
            S_MANUAL: mode = MODE_MANUAL;
            default:  mode = MODE_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and command selection
    always_comb begin
        state_n       = state;
        issue_load    = 1'b0;
        issue_mode_n  = MODE_MOTION;
        issue_angle_n = rr_winner;
        case (state)
            S_IDLE: begin
                if (eff_rem) begin
                    state_n       = S_ISSUE;
                    issue_load    = 1'b1;
                    issue_mode_n  = MODE_MANUAL;
                    issue_angle_n = eff_rem_angle;
                end else if (rr_found) begin
                    state_n    = S_ISSUE;
                    issue_load = 1'b1;
                end else if (PATROL_EN && counter == PATROL_LAST) begin
                    state_n       = S_ISSUE;
                    issue_load    = 1'b1;
                    issue_mode_n  = MODE_PATROL;
                    issue_angle_n = cur_angle + 2'd1;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    case (issue_mode)
                        MODE_MOTION: state_n = S_DWELL;
                        MODE_MANUAL: state_n = S_MANUAL;
                        default:     state_n = S_IDLE;
                    endcase
                end
            end
            S_DWELL, S_MANUAL: begin
                // A remote request cuts a dwell short and restarts a manual hold.
                if (eff_rem) begin
                    state_n       = S_ISSUE;
                    issue_load    = 1'b1;
                    issue_mode_n  = MODE_MANUAL;
                    issue_angle_n = eff_rem_angle;
                end else if (counter == '0) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: request latches, command registers, shared counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            rem_pend   <= 1'b0;
            rem_angle  <= '0;
            rr_ptr     <= '0;
            issue_mode <= MODE_IDLE;
            cmd_angle  <= '0;
            cur_angle  <= '0;
            counter    <= '0;
        end else begin
            // New motion wins over a same-cycle clear.
            pend <= (pend & ~zone_clr) | motion_zone;

            if (remote_req) begin
                rem_pend  <= 1'b1;
                rem_angle <= remote_angle;
            end else if (transfer && issue_mode == MODE_MANUAL) begin
                rem_pend <= 1'b0;
            end

            if (issue_load) begin
                issue_mode <= issue_mode_n;
                cmd_angle  <= issue_angle_n;
            end

            if (transfer) begin
                cur_angle <= cmd_angle;
                if (issue_mode == MODE_MOTION) begin
                    rr_ptr <= cmd_angle + 2'd1;
                end
            end

            // One counter serves dwell, manual hold and (optionally) idle run length.
            if (transfer) begin
                case (issue_mode)
                    MODE_MOTION: counter <= DWELL_LOAD;
                    MODE_MANUAL: counter <= HOLD_LOAD;
                    default:     counter <= '0;
                endcase
            end else begin
                case (state)
                    S_DWELL, S_MANUAL: begin
                        if (counter != '0) begin
                            counter <= counter - 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (state_n != S_IDLE) begin
                            counter <= '0;
                        end else if (PATROL_EN) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_angle_scheduler.sv
// Bench for camera_angle_scheduler with DWELL_CYCLES=4, MANUAL_HOLD=8,
// PATROL_CYCLES=10. A behavioural model tracks pending requests, the
// command in flight and the remaining hold time; a compare process checks
// the DUT against it every cycle. Directed scenarios pin known values.

`timescale 1ns/1ps

module tb_camera_angle_scheduler;

    localparam int DW = 4;
    localparam int MH = 8;
    localparam int PC = 10;

`ifdef CAM_PATROL_EN
    localparam bit PATROL_ON = 1'b1;
`else
    localparam bit PATROL_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] motion_zone = '0;
    logic       remote_req = 1'b0;
    logic [1:0] remote_angle = '0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_angle;
    logic [1:0] cur_angle;
    logic [1:0] mode;
    logic       busy;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    camera_angle_scheduler #(
        .DWELL_CYCLES (DW),
        .MANUAL_HOLD  (MH),
        .PATROL_CYCLES(PC),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .motion_zone (motion_zone),
        .remote_req  (remote_req),
        .remote_angle(remote_angle),
        .cmd_valid   (cmd_valid),
        .cmd_angle   (cmd_angle),
        .cmd_ready   (cmd_ready),
        .cur_angle   (cur_angle),
        .mode        (mode),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0] m_pend;
    bit       m_rem_pend;
    int       m_rem_angle;
    int       m_rr;
    int       m_cur;
    bit       m_issuing;
    int       m_cmd_angle;
    int       m_cmd_mode;   // 1 motion, 2 manual, 3 patrol
    int       m_hold_left;  // cycles of dwell/hold still to be spent
    int       m_hold_kind;
    int       m_idle_run;

    task automatic m_reset();
        m_pend = '0; m_rem_pend = 0; m_rem_angle = 0; m_rr = 0; m_cur = 0;
        m_issuing = 0; m_cmd_angle = 0; m_cmd_mode = 0;
        m_hold_left = 0; m_hold_kind = 0; m_idle_run = 0;
    endtask

    task automatic m_step(input bit [3:0] z, input bit rq, input int ra, input bit rdy);
        bit [3:0] ez;
        bit       erem;
        int       eang;
        bit       go;
        int       gang;
        int       gmode;
        ez    = m_pend | z;
        erem  = m_rem_pend | rq;
        eang  = rq ? ra : m_rem_angle;
        go    = 0;
        gang  = 0;
        gmode = 0;
        if (m_issuing) begin
            if (rdy) begin
                m_issuing = 0;
                m_cur = m_cmd_angle;
                if (m_cmd_mode == 1) begin
                    m_pend[m_cmd_angle] = 0;
                    m_rr = (m_cmd_angle + 1) % 4;
                    m_hold_left = DW; m_hold_kind = 1;
                end else if (m_cmd_mode == 2) begin
                    m_rem_pend = 0;
                    m_hold_left = MH; m_hold_kind = 2;
                end
            end
        end else if (m_hold_left > 0) begin
            if (erem) begin
                go = 1; gang = eang; gmode = 2; m_hold_left = 0;
            end else begin
                m_hold_left--;
            end
        end else begin
            if (erem) begin
                go = 1; gang = eang; gmode = 2;
            end else if (ez != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (!go && ez[(m_rr + k) % 4]) begin
                        go = 1; gang = (m_rr + k) % 4; gmode = 1;
                    end
                end
            end else if (PATROL_ON) begin
                m_idle_run++;
                if (m_idle_run == PC) begin
                    go = 1; gang = (m_cur + 1) % 4; gmode = 3;
                end
            end
        end
        if (go) begin
            m_issuing = 1; m_cmd_angle = gang; m_cmd_mode = gmode;
        end
        if (m_issuing || m_hold_left > 0) m_idle_run = 0;
        m_pend = m_pend | z;
        if (rq) begin
            m_rem_pend = 1; m_rem_angle = ra;
        end
    endtask

    initial m_reset();

    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step(motion_zone, remote_req, int'(remote_angle), cmd_ready);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int exp_mode;
        exp_mode = m_issuing ? m_cmd_mode : (m_hold_left > 0 ? m_hold_kind : 0);
        check("cmd_valid", cmd_valid, m_issuing);
        if (m_issuing) check("cmd_angle", cmd_angle, m_cmd_angle);
        check("cur_angle", cur_angle, m_cur);
        check("mode", mode, exp_mode);
        check("busy", busy, (m_issuing || m_hold_left > 0));
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        motion_zone = '0; remote_req = 0; cmd_ready = 1;
        #2 rst = 1'b1;
        m_reset();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dens;
        // reset state
        next_cycle(2);
        check("rst_valid", cmd_valid, 0);
        check("rst_cur", cur_angle, 0);
        check("rst_mode", mode, 0);
        check("rst_busy", busy, 0);
        #2 rst = 1'b0;

        // 1: single motion on zone 1
        next_cycle(1); motion_zone = 4'b0010;
        next_cycle(1); motion_zone = 4'b0000;
        check("t1_valid", cmd_valid, 1);
        check("t1_angle", cmd_angle, 1);
        check("t1_mode", mode, 1);
        next_cycle(1);
        check("t1_cur", cur_angle, 1);
        check("t1_dwell_valid", cmd_valid, 0);
        check("t1_dwell_mode", mode, 1);
        next_cycle(3);
        check("t1_last_dwell", busy, 1);
        next_cycle(1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_mode", mode, 0);

        // 2: three zones in round-robin order
        do_reset();
        next_cycle(1); motion_zone = 4'b1011;
        next_cycle(1); motion_zone = 4'b0000;
        check("t2_first", cmd_angle, 0);
        next_cycle(6);
        check("t2_second_v", cmd_valid, 1);
        check("t2_second", cmd_angle, 1);
        next_cycle(6);
        check("t2_third_v", cmd_valid, 1);
        check("t2_third", cmd_angle, 3);
        next_cycle(5);
        check("t2_idle", busy, 0);
        next_cycle(1); motion_zone = 4'b1111;
        next_cycle(1); motion_zone = 4'b0000;
        check("t2_rr_wrap", cmd_angle, 0);

        // 3: remote aborts dwell, motion waits out manual hold
        do_reset();
        next_cycle(1); motion_zone = 4'b0100;
        next_cycle(1); motion_zone = 4'b0000;
        check("t3_motion", cmd_angle, 2);
        next_cycle(1); remote_req = 1; remote_angle = 2'd3;
        next_cycle(1); remote_req = 0;
        check("t3_man_valid", cmd_valid, 1);
        check("t3_man_angle", cmd_angle, 3);
        check("t3_man_mode", mode, 2);
        check("t3_cur_before", cur_angle, 2);
        next_cycle(1); motion_zone = 4'b0010;
        check("t3_hold_cur", cur_angle, 3);
        next_cycle(1); motion_zone = 4'b0000;
        check("t3_hold_ignores", cmd_valid, 0);
        next_cycle(6);
        check("t3_hold_last", mode, 2);
        next_cycle(1);
        check("t3_hold_done", busy, 0);
        next_cycle(1);
        check("t3_zone1_v", cmd_valid, 1);
        check("t3_zone1", cmd_angle, 1);
        check("t3_zone1_mode", mode, 1);

        // 4: stalled handshake keeps command stable, remote queued behind it
        do_reset();
        next_cycle(1); motion_zone = 4'b0100; cmd_ready = 0;
        next_cycle(1); motion_zone = 4'b0000; remote_req = 1; remote_angle = 2'd0;
        check("t4_valid", cmd_valid, 1);
        check("t4_angle", cmd_angle, 2);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1); remote_req = 0;
            check("t4_stall_v", cmd_valid, 1);
            check("t4_stall_a", cmd_angle, 2);
        end
        next_cycle(1); cmd_ready = 1;
        next_cycle(1);
        check("t4_dwell_cur", cur_angle, 2);
        check("t4_dwell_mode", mode, 1);
        next_cycle(1);
        check("t4_rem_angle", cmd_angle, 0);
        check("t4_rem_mode", mode, 2);

        // 5: reset mid-handshake
        do_reset();
        next_cycle(1); motion_zone = 4'b1000;
        next_cycle(1); motion_zone = 4'b0000;
        next_cycle(5); motion_zone = 4'b0011; cmd_ready = 0;
        next_cycle(1); motion_zone = 4'b1100;
        check("t5_valid", cmd_valid, 1);
        check("t5_angle", cmd_angle, 0);
        check("t5_cur", cur_angle, 3);
        next_cycle(1); motion_zone = 4'b0000;
        #2 rst = 1'b1;
        m_reset();
        #1;
        check("t5_rst_valid", cmd_valid, 0);
        check("t5_rst_angle", cmd_angle, 0);
        check("t5_rst_cur", cur_angle, 0);
        check("t5_rst_mode", mode, 0);
        check("t5_rst_busy", busy, 0);
        next_cycle(1);
        #2 rst = 1'b0; cmd_ready = 1;
        next_cycle(4);
        check("t5_discard", cmd_valid, 0);

        // 6: patrol step (or indefinite idle without the feature)
        do_reset();
        next_cycle(1); motion_zone = 4'b1000;
        next_cycle(1); motion_zone = 4'b0000;
        next_cycle(15);
        if (PATROL_ON) begin
            check("t6_patrol_v", cmd_valid, 1);
            check("t6_patrol_a", cmd_angle, 0);
            check("t6_patrol_m", mode, 3);
        end else begin
            check("t6_no_patrol", cmd_valid, 0);
            next_cycle(100);
            check("t6_still_idle", busy, 0);
        end

        // randomized traffic, varying request density
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            dens = $urandom_range(2, 30);
            for (int i = 0; i < 500; i++) begin
                next_cycle(1);
                motion_zone  = ($urandom_range(0, dens) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                remote_req   = ($urandom_range(0, 3 * dens) == 0);
                remote_angle = 2'($urandom_range(0, 3));
                cmd_ready    = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst = 1'b1;
                    m_reset();
                    next_cycle(1);
                    #2 rst = 1'b0;
                end
            end
        end
        next_cycle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
